// File: rtl/adc_in.sv
// ADC input scaler: boxcar-averages 2^AVG_LOG2 signed ADC codes and converts the
// mean to the signed fixed-point voltage word, V = -code*20/2^ADC_WIDTH.
module adc_in #(
  parameter int FLOAT_WIDTH = 64,
  parameter int INT_WIDTH   = 16,
  parameter int ADC_WIDTH   = 14,
  parameter int AVG_LOG2    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic [ADC_WIDTH-1:0]   adc_code,
  input  logic                   adc_valid,
  output logic [FLOAT_WIDTH-1:0] volt_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   overrun
);

  localparam int FRAC  = FLOAT_WIDTH - INT_WIDTH;
  localparam int SHIFT = FRAC - (ADC_WIDTH - 2);
  localparam int ACC_W = ADC_WIDTH + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  // Output handshake: a result is transferred on any rising edge where
  // out_valid and out_ready are both high; adc_valid has no back-pressure.

  logic signed [ACC_W-1:0]       r_acc;
  logic        [CNT_W-1:0]       r_cnt;
  logic signed [ACC_W-1:0]       r_mean;
  logic                          r_s1_valid;
  logic signed [ACC_W-1:0]       w_code_ext;
  logic signed [ACC_W-1:0]       w_sum;
  logic signed [FLOAT_WIDTH-1:0] w_mean_ext;
  logic signed [FLOAT_WIDTH-1:0] w_times5;
  logic signed [FLOAT_WIDTH-1:0] w_volt;

  assign w_code_ext = ACC_W'($signed(adc_code));
  assign w_sum      = r_acc + w_code_ext;

  // The mean always fits in ADC_WIDTH bits, so the scaled word is exact.
  assign w_mean_ext = FLOAT_WIDTH'(r_mean);
  assign w_times5   = (w_mean_ext <<< 2) + w_mean_ext;
  assign w_volt     = (-w_times5) <<< SHIFT;

  // Stage 1: accumulate one group; clear discards a partial group and any sample on that edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_mean     <= '0;
      r_s1_valid <= 1'b0;
    end else if (clear) begin
      r_acc      <= '0;
      r_cnt      <= '0;
      r_s1_valid <= 1'b0;
    end else if (adc_valid) begin
      if (r_cnt == CNT_LAST) begin
        r_mean     <= w_sum >>> AVG_LOG2;
        r_acc      <= '0;
        r_cnt      <= '0;
        r_s1_valid <= 1'b1;
      end else begin
        r_acc      <= w_sum;
        r_cnt      <= r_cnt + CNT_W'(1);
        r_s1_valid <= 1'b0;
      end
    end else begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage 2: output register; a stage-1 result is never blocked, even by clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      volt_out  <= '0;
      out_valid <= 1'b0;
    end else if (r_s1_valid) begin
      volt_out  <= w_volt;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (clear) begin
      overrun <= 1'b0;
    end else if (r_s1_valid && out_valid && !out_ready) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: doc/adc_in.md
Name: adc_in

Overview:
- ADC-side counterpart of the DAC output scaler: converts signed ADC_WIDTH-bit ADC codes into the Q(INT_WIDTH).(FLOAT_WIDTH-INT_WIDTH) fixed-point voltage format used by the SPGD datapath.
- Boxcar-averages 2^AVG_LOG2 consecutive samples, then applies the inverse DAC transfer: V = -code*20/2^ADC_WIDTH, i.e. -code*5/4096 for 14 bits.
- Two-stage pipeline with a valid/ready output register feeding the SPGD metric logic.

Parameters:
- FLOAT_WIDTH, 64, width of the fixed-point voltage word.
- INT_WIDTH, 16, signed integer bits of the voltage word; FRAC = FLOAT_WIDTH-INT_WIDTH = 48.
- ADC_WIDTH, 14, ADC code width, two's complement.
- AVG_LOG2, 2, log2 of samples per average; legal range 0..8.
- Constraint: FRAC >= ADC_WIDTH-2.

Ports:
- clk  in  1  system clock; every register updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush of the averaging state and of the overrun flag.
- adc_code  in  ADC_WIDTH  signed ADC sample.
- adc_valid  in  1  adc_code is sampled on this edge.
- volt_out  out  FLOAT_WIDTH  signed fixed-point voltage.
- out_valid  out  1  volt_out holds an unconsumed result.
- out_ready  in  1  consumer accepts; a transfer occurs on an edge where out_valid and out_ready are both high.
- overrun  out  1  sticky flag: a result was overwritten before it was consumed.

Behaviour:
- Reset values (async, while rst=1): volt_out=0, out_valid=0, overrun=0, acc=0, cnt=0, mean_reg=0, s1_valid=0.
- Stage 1, accumulate (acc is a signed ADC_WIDTH+AVG_LOG2 bit register):
  - On an adc_valid edge with cnt<N-1: acc<=acc+code, cnt++, s1_valid<=0.
  - On an adc_valid edge with cnt==N-1: mean_reg<=(acc+code)>>>AVG_LOG2 (arithmetic shift, floors toward -inf), acc<=0, cnt<=0, s1_valid<=1.
  - Otherwise s1_valid<=0. With AVG_LOG2=0, every valid sample completes a group.
- Stage 2, scale:
  - When s1_valid=1: volt_out <= -(mean_reg*5) << (FRAC-(ADC_WIDTH-2)), sign-extended to FLOAT_WIDTH, and out_valid<=1.
  - Exact; no rounding or saturation. Code -2^(ADC_WIDTH-1) maps to +10.0 and fits in INT_WIDTH.
- Latency: last sample of a group captured on edge k; volt_out and out_valid update on edge k+1.
- Throughput: one sample per clock, never stalls. adc_valid has no back-pressure.
- Output handshake:
  - A transfer with no new stage-2 result that edge: out_valid<=0; volt_out holds its value.
  - New result and transfer on the same edge: load the new value, keep out_valid=1, no overrun.
  - New result while out_valid=1 and out_ready=0: overwrite volt_out, set overrun<=1.
- clear:
  - Sets acc=0, cnt=0, s1_valid=0 and overrun=0; a partial group is discarded.
  - volt_out and out_valid are untouched, so a pending result is still delivered.
  - clear and adc_valid on the same edge: clear wins and the sample is dropped.
  - A result already in stage 1 (s1_valid=1) on a clear edge is still written to stage 2.
- rst mid-group or mid-pipeline: all state returns to reset values immediately. The next group starts from the first adc_valid after release.
- overrun clears only on rst or clear.

Test Plan:
- AVG_LOG2=0, out_ready=1; codes 0, 0x2000(-8192), 0x1000(4096), 1, 0x1FFF(8191) on consecutive cycles -> volt_out 0x0, 0x000A_0000_0000_0000, 0xFFFB_0000_0000_0000, 0xFFFF_FFB0_0000_0000, 0xFFF6_0050_0000_0000. Each appears one edge after capture; out_valid stays high throughout.
- AVG_LOG2=2; codes 100,101,102,103 -> single result 0xFFFF_E070_0000_0000 (mean 101). Codes -1,-1,-1,-2 -> 0x0000_00A0_0000_0000 (mean floors to -2). out_valid pulses once per 4 samples.
- AVG_LOG2=0, out_ready=0; two samples 1 then 2 -> volt_out shows the second result, out_valid=1, overrun=1. Raise out_ready -> one transfer, then out_valid=0. Pulse clear -> overrun=0.
- AVG_LOG2=2; two samples, then clear, then 100,101,102,103 -> exactly one result, mean 101. Also: clear asserted together with adc_valid -> that sample is not counted.
- Assert rst after 3 of 4 samples, with out_valid=1 -> outputs go to zero immediately, without waiting for a clock edge. Four samples after release produce a correct result.
- Random codes with random adc_valid/out_ready, AVG_LOG2 in {0,3} -> every transferred value matches the reference model; no value is lost without overrun being set.
